// File: rtl/sub64_4stage_pipe.sv
// sub64_4stage_pipe: 64-bit unsigned subtractor, 4-stage pipeline, one 16-bit slice resolved per stage.
// Optional build macro SUB64_SAT_EN clamps diff to zero whenever the overall result borrows.
module sub64_4stage_pipe #(
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] x,
   input  logic [DATA_W-1:0] y,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] diff,
   output logic              borrow
);
   localparam int SLICE_W = DATA_W / 4;
   localparam int NST     = 4;

   logic [NST-1:0] v_s;
   logic [NST-1:0] en_s;
   logic           en1_s;
   logic           en2_s;
   logic           en3_s;
   logic           en4_s;

   // A stage advances when it is empty or when its successor advances, so bubbles collapse.
   assign en4_s    = ~v_s[3] | out_ready;
   assign en3_s    = ~v_s[2] | en4_s;
   assign en2_s    = ~v_s[1] | en3_s;
   assign en1_s    = ~v_s[0] | en2_s;
   assign en_s     = {en4_s, en3_s, en2_s, en1_s};
   assign in_ready = en1_s;

   for (genvar i = 0; i < NST; i++) begin : g_stage
      localparam int UW = (NST - i) * SLICE_W;
      localparam int DW = (i + 1) * SLICE_W;

      logic [UW-1:0]      xs_s;
      logic [UW-1:0]      ys_s;
      logic               bp_s;
      logic               vp_s;
      logic               sat_s;
      logic [SLICE_W:0]   res_s;
      logic [DW-1:0]      dn_s;
      logic [DW-1:0]      dq_s;
      logic [DW-1:0]      d_r;
      logic               v_r;
      logic               b_r;

      if (i == 0) begin : g_head
         assign xs_s = x;
         assign ys_s = y;
         assign bp_s = 1'b0;
         assign vp_s = in_valid;
         assign dn_s = res_s[SLICE_W-1:0];
      end else begin : g_body
         assign xs_s = g_stage[i-1].g_carry.xu_r;
         assign ys_s = g_stage[i-1].g_carry.yu_r;
         assign bp_s = g_stage[i-1].b_r;
         assign vp_s = g_stage[i-1].v_r;
         assign dn_s = {res_s[SLICE_W-1:0], g_stage[i-1].d_r};
      end

      // Lowest unresolved slice; the extra MSB is the borrow into the next slice.
      assign res_s = {1'b0, xs_s[SLICE_W-1:0]} - {1'b0, ys_s[SLICE_W-1:0]}
                   - {{SLICE_W{1'b0}}, bp_s};

`ifdef SUB64_SAT_EN
      assign sat_s = (i == NST - 1) ? res_s[SLICE_W] : 1'b0;
`else
      assign sat_s = 1'b0;
`endif

      // Result slices entering the stage register, clamped to zero on a saturating final borrow.
      always_comb begin
         dq_s = dn_s;
         if (sat_s) begin
            dq_s = '0;
         end else begin
            dq_s = dn_s;
         end
      end

      // Stage valid, borrow and resolved-slice registers; hold while stalled.
      always_ff @(posedge clk) begin
         if (rst) begin
            v_r <= 1'b0;
            b_r <= 1'b0;
            d_r <= '0;
         end else if (en_s[i]) begin
            v_r <= vp_s;
            b_r <= res_s[SLICE_W];
            d_r <= dq_s;
         end
      end

      assign v_s[i] = v_r;

      if (i < NST - 1) begin : g_carry
         logic [UW-SLICE_W-1:0] xu_r;
         logic [UW-SLICE_W-1:0] yu_r;

         // Unresolved upper operand slices travel alongside the partial result.
         always_ff @(posedge clk) begin
            if (rst) begin
               xu_r <= '0;
               yu_r <= '0;
            end else if (en_s[i]) begin
               xu_r <= xs_s[UW-1:SLICE_W];
               yu_r <= ys_s[UW-1:SLICE_W];
            end
         end
      end
   end

   assign out_valid = g_stage[NST-1].v_r;
   assign diff      = g_stage[NST-1].d_r;
   assign borrow    = g_stage[NST-1].b_r;

endmodule

// File: tb/tb_sub64_4stage_pipe.sv
// tb_sub64_4stage_pipe: directed checks for sub64_4stage_pipe (honours SUB64_SAT_EN if defined).
module tb_sub64_4stage_pipe;
   localparam int W = 64;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] x;
   logic [W-1:0] y;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         borrow;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] xs [16];
   logic [W-1:0] ys [16];
   logic [W:0]   expq [$];
   logic [W:0]   e;
   logic [W-1:0] held_d;
   logic         held_b;
   logic         stalled;
   int           sent;
   int           recv;
   int           cyc;

   always #5 clk = ~clk;

   sub64_4stage_pipe #(.DATA_W(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .borrow(borrow)
   );

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Full-width reference, independent of the slicing.
   function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] r;
      r = {1'b0, a} - {1'b0, b};
`ifdef SUB64_SAT_EN
      if (r[W]) r[W-1:0] = '0;
`endif
      return r;
   endfunction

   task automatic run_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ed, input logic eb);
      x = a; y = b; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      check({tag, "_in_ready"}, in_ready, 1);
      tick;
      in_valid = 1'b0;
      tick;
      tick;
      check({tag, "_early_valid"}, out_valid, 0);
      tick;
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_diff"}, diff, ed);
      check({tag, "_borrow"}, borrow, eb);
      tick;
      check({tag, "_valid_drop"}, out_valid, 0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0;
      repeat (2) tick;
      check("rst_out_valid", out_valid, 0);
      check("rst_diff", diff, 0);
      check("rst_borrow", borrow, 0);
      rst = 1'b0;
      #1;
      check("rst_in_ready", in_ready, 1);

      run_one("t1_5m3", 64'd5, 64'd3, 64'd2, 1'b1 & 1'b0);
`ifdef SUB64_SAT_EN
      run_one("t2_0m1", 64'd0, 64'd1, 64'd0, 1'b1);
      run_one("t2b_1mmax", 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
`else
      run_one("t2_0m1", 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      run_one("t2b_1mmax", 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1);
`endif
      run_one("t3_ripple", 64'h0001_0000_0000_0000, 64'd1, 64'h0000_FFFF_FFFF_FFFF, 1'b0);
      run_one("t4_equal", 64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D, 64'd0, 1'b0);
      run_one("t4b_msb", 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);

      // Back-to-back stream with out_ready pattern 1,0,0,1.
      for (int i = 0; i < 16; i++) begin
         xs[i] = {$urandom, $urandom};
         ys[i] = {$urandom, $urandom};
      end
      xs[3] = 64'h0000_0000_0001_0000;
      ys[3] = 64'h0000_0000_0000_0001;
      sent = 0; recv = 0; cyc = 0; stalled = 1'b0; held_d = '0; held_b = 1'b0;
      while (recv < 16 && cyc < 200) begin
         out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         in_valid  = (sent < 16);
         if (sent < 16) begin
            x = xs[sent];
            y = ys[sent];
         end
         #1;
         if (stalled) begin
            check("t5_hold_valid", out_valid, 1);
            check("t5_hold_diff", diff, held_d);
            check("t5_hold_borrow", borrow, held_b);
         end
         check("t5_in_ready", in_ready, !((sent - recv) == 4 && !out_ready));
         if (out_valid && out_ready) begin
            check("t5_spurious_out", expq.size() != 0, 1);
            if (expq.size() != 0) begin
               e = expq.pop_front();
               check("t5_diff", diff, e[W-1:0]);
               check("t5_borrow", borrow, e[W]);
            end
            recv++;
         end
         stalled = out_valid && !out_ready;
         held_d  = diff;
         held_b  = borrow;
         if (in_valid && in_ready) begin
            expq.push_back(model(x, y));
            sent++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      in_valid = 1'b0;
      check("t5_all_results", recv, 16);
      out_ready = 1'b1;
      repeat (6) tick;

      // Reset with three operations in flight.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         x = 64'd100 + 64'(i);
         y = 64'd1;
         tick;
      end
      in_valid = 1'b0;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check("t6_rst_valid", out_valid, 0);
      check("t6_rst_diff", diff, 0);
      check("t6_rst_borrow", borrow, 0);
      check("t6_rst_in_ready", in_ready, 1);
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick;
         check("t6_no_stale", out_valid, 0);
      end
      run_one("t6_9m4", 64'd9, 64'd4, 64'd5, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
